// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_t       : issue opcode carried on muldiv_if.op
//   state_t    : FSM state, also exported on the dbg_state port
//   *_DEF      : default busy latencies for multiply and divide
//   DATA_W     : operand / HI / LO width
//   DIV_STEPS  : restoring-division iterations (one quotient bit each)
package muldiv_pkg;

    localparam int DATA_W      = 32;
    localparam int DIV_STEPS   = 32;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 34;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
//   start, op, a, b : issue request from EX (master -> slave)
//   busy            : unit occupied (slave -> master)
//   hi, lo          : architectural HI/LO registers (slave -> master)
//
// Handshake: start acts as "valid" and !busy as "ready". An issue is taken
// on a rising edge where start=1 and busy=0; start while busy=1 is dropped
// with no effect (the hazard unit is expected to stall around it).
interface muldiv_if;
    import muldiv_pkg::*;

    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration.
//   rem_in       : current partial remainder
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : unsigned divisor
//   rem_out      : partial remainder after the trial subtraction
//   q_bit        : quotient bit produced by this iteration
module div_step
    import muldiv_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    // One extra bit so the shifted remainder never overflows; the restored
    // or reduced result is always below the divisor and fits DATA_W bits.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DATA_W];
    assign rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS-style multiply/divide unit owning the HI/LO registers.
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   bus       : muldiv_if.slave -- start/op/a/b in, busy/hi/lo out
//   dbg_state : current FSM state
// MULT/MULTU keep busy for MUL_LAT cycles, DIV/DIVU for DIV_LAT cycles
// (load, DIV_STEPS iterations, sign fix). MTHI/MTLO write in one edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    muldiv_if.slave bus,
    output state_t dbg_state
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  opa;       // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0]  opb;       // multiplier, or divisor
    logic [DATA_W-1:0]  rem;
    logic               mul_signed;
    logic               neg_q;
    logic               neg_r;
    logic [DATA_W-1:0]  hi_r, lo_r;

    op_t  op_in;
    logic accept;
    logic is_mul, is_div;
    logic busy, mul_done, step_en, fix_en;

    assign op_in  = op_t'(bus.op);
    assign accept = bus.start && (state == ST_IDLE);
    assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU);
    assign is_div = (op_in == OP_DIV)  || (op_in == OP_DIVU);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul)      state_nxt = ST_MUL;
                else if (accept && is_div) state_nxt = ST_DIV;
            end
            ST_MUL:  if (cnt == '0) state_nxt = ST_IDLE;
            ST_DIV:  if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode. The first DIV cycle (counter above the
    // iteration range) is the load cycle and performs no step.
    always_comb begin
        busy     = (state != ST_IDLE);
        mul_done = (state == ST_MUL) && (cnt == '0);
        step_en  = (state == ST_DIV) && (cnt < CNT_W'(DIV_STEPS));
        fix_en   = (state == ST_FIX);
    end

    logic [DATA_W-1:0] step_rem;
    logic              step_q;

    div_step u_div_step (
        .rem_in       (rem),
        .dividend_bit (opa[DATA_W-1]),
        .divisor      (opb),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // A single 64x64 multiplier covers both signednesses: the low 64 bits
    // of the product of extended operands are correct either way.
    logic [2*DATA_W-1:0] ext_a, ext_b, product;
    assign ext_a   = mul_signed ? {{DATA_W{opa[DATA_W-1]}}, opa} : {{DATA_W{1'b0}}, opa};
    assign ext_b   = mul_signed ? {{DATA_W{opb[DATA_W-1]}}, opb} : {{DATA_W{1'b0}}, opb};
    assign product = ext_a * ext_b;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            if (accept) begin
                case (op_in)
                    OP_MULT, OP_MULTU: begin
                        cnt        <= CNT_W'(MUL_LAT - 1);
                        opa        <= bus.a;
                        opb        <= bus.b;
                        mul_signed <= (op_in == OP_MULT);
                    end
                    OP_DIV: begin
                        cnt   <= CNT_W'(DIV_LAT - 2);
                        opa   <= bus.a[DATA_W-1] ? -bus.a : bus.a;
                        opb   <= bus.b[DATA_W-1] ? -bus.b : bus.b;
                        rem   <= '0;
                        neg_q <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
                        neg_r <= bus.a[DATA_W-1];
                    end
                    OP_DIVU: begin
                        cnt   <= CNT_W'(DIV_LAT - 2);
                        opa   <= bus.a;
                        opb   <= bus.b;
                        rem   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
                    OP_MTHI: hi_r <= bus.a;
                    OP_MTLO: lo_r <= bus.a;
                    default: ;
                endcase
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (mul_done) begin
                {hi_r, lo_r} <= product;
            end

            if (step_en) begin
                rem <= step_rem;
                opa <= {opa[DATA_W-2:0], step_q};
            end

            // Divide by zero leaves HI/LO untouched.
            if (fix_en && opb != '0) begin
                lo_r <= neg_q ? -opa : opa;
                hi_r <= neg_r ? -rem : rem;
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     pass_cnt;
    int     total_cnt;

    muldiv_if bus ();

    muldiv_unit #(.MUL_LAT(5), .DIV_LAT(34)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present an issue at the negedge, release start #1 after the edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
    endtask

    // Counts negedges with busy=1 until busy drops, bounded at 200.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", bus.lo); else pass_cnt++;
        total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mult_busy_start got %b exp 1", bus.busy); else pass_cnt++;
        total_cnt++; if (dbg_state !== ST_MUL) $display("FAIL mult_state got %0d exp %0d", dbg_state, ST_MUL); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL mult_hi_hold got %h exp 0", bus.hi); else pass_cnt++;
        wait_idle(n);
        total_cnt++; if (n !== 5) $display("FAIL mult_cycles got %0d exp 5", n); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h exp fffffffa", bus.lo); else pass_cnt++;
    endtask

    task automatic test_multu();
        int n;
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        total_cnt++; if (n !== 5) $display("FAIL multu_cycles got %0d exp 5", n); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h2) $display("FAIL multu_hi got %h exp 2", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL multu_lo got %h exp fffffffa", bus.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int n;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        total_cnt++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL div_lo_hold got %h exp fffffffa", bus.lo); else pass_cnt++;
        wait_idle(n);
        total_cnt++; if (n !== 34) $display("FAIL div_cycles got %0d exp 34", n); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", bus.hi); else pass_cnt++;
    endtask

    task automatic test_divu();
        int n;
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        total_cnt++; if (n !== 34) $display("FAIL divu_cycles got %0d exp 34", n); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'd3) $display("FAIL divu_lo got %h exp 3", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'd1) $display("FAIL divu_hi got %h exp 1", bus.hi); else pass_cnt++;
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        total_cnt++; if (bus.hi !== 32'hDEAD_BEEF) $display("FAIL mthi_hi got %h exp deadbeef", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy got %b exp 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'd3) $display("FAIL mthi_lo_keep got %h exp 3", bus.lo); else pass_cnt++;
        issue(3'd6, 32'h2222_2222, 32'h0);
        total_cnt++; if (bus.lo !== 32'h2222_2222) $display("FAIL mtlo_lo got %h exp 22222222", bus.lo); else pass_cnt++;
        issue(3'd5, 32'h1111_1111, 32'h0);
    endtask

    task automatic test_nop();
        issue(3'd0, 32'h1234_5678, 32'h9);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL nop_busy got %b exp 0", bus.busy); else pass_cnt++;
        issue(3'd7, 32'h1234_5678, 32'h9);
        @(negedge clk);
        total_cnt++; if (bus.hi !== 32'h1111_1111) $display("FAIL rsvd_hi got %h exp 11111111", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h2222_2222) $display("FAIL rsvd_lo got %h exp 22222222", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rsvd_busy got %b exp 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int n;
        issue(3'd4, 32'd5, 32'd0);
        wait_idle(n);
        total_cnt++; if (n !== 34) $display("FAIL divz_cycles got %0d exp 34", n); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h1111_1111) $display("FAIL divz_hi got %h exp 11111111", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h2222_2222) $display("FAIL divz_lo got %h exp 22222222", bus.lo); else pass_cnt++;
    endtask

    task automatic test_div_overflow();
        int n;
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total_cnt++; if (bus.lo !== 32'h8000_0000) $display("FAIL divovf_lo got %h exp 80000000", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL divovf_hi got %h exp 0", bus.hi); else pass_cnt++;
    endtask

    task automatic test_mtlo_busy();
        int n;
        issue(3'd6, 32'h55, 32'h0);
        issue(3'd2, 32'd3, 32'd4);
        issue(3'd6, 32'hAAAA_AAAA, 32'h0);
        total_cnt++; if (bus.lo !== 32'h55) $display("FAIL mtlo_busy_lo got %h exp 55", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mtlo_busy_busy got %b exp 1", bus.busy); else pass_cnt++;
        wait_idle(n);
        total_cnt++; if (n !== 4) $display("FAIL mtlo_busy_cycles got %0d exp 4", n); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'd12) $display("FAIL mtlo_busy_result got %h exp c", bus.lo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'd1, 32'd100, 32'hFFFF_FFFF);
        issue(3'd3, 32'd9, 32'd3);
        wait_idle(n);
        total_cnt++; if (n !== 4) $display("FAIL b2b_cycles got %0d exp 4", n); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL b2b_hi got %h exp ffffffff", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FF9C) $display("FAIL b2b_lo got %h exp ffffff9c", bus.lo); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b_div_dropped got %b exp 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FF9C) $display("FAIL b2b_lo_stable got %h exp ffffff9c", bus.lo); else pass_cnt++;
    endtask

    task automatic test_rst_abort();
        int n;
        issue(3'd3, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL abort_hi got %h exp 0", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h0) $display("FAIL abort_lo got %h exp 0", bus.lo); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        wait_idle(n);
        total_cnt++; if (n !== 5) $display("FAIL abort_mul_cycles got %0d exp 5", n); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'd42) $display("FAIL abort_mul_lo got %h exp 2a", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL abort_mul_hi got %h exp 0", bus.hi); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_mthi_mtlo();
        test_nop();
        test_div_zero();
        test_div_overflow();
        test_mtlo_busy();
        test_back_to_back();
        test_rst_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
